// File: rtl/spi_slave_port.sv
// SPI mode-0 slave peripheral on the CPU I/O bus: 8-bit MSB-first frames with RX/TX hold
// registers, an overrun flag and a level interrupt.
module spi_slave_port #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       intr
);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, csn_sync;
  logic                   sck_prev, csn_prev;
  logic [SYNC_STAGES:0]   fill;
  logic                   armed;

  logic [6:0] rxsh;
  logic [7:0] txsh;
  logic [2:0] bitcnt;
  logic [7:0] tx_hold, rx_hold, idle_reg;
  logic [2:0] ctrl;
  logic       txf, rxf, ovr, rd_prev;

  logic sck_s, mosi_s, csn_s;
  logic sck_rise, sck_fall, csn_fall;
  logic frame_start, shift_in, shift_out, byte_done, load_tx;
  logic wr, rd_data, rd_clear;
  logic [7:0] rx_byte;

  // Pin synchronisers. A frame only becomes valid once cs_n has been seen high through
  // a fully refilled chain, so a host holding cs_n low across reset is ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_sync  <= '1;
      mosi_sync <= '1;
      csn_sync  <= '1;
      sck_prev  <= 1'b1;
      csn_prev  <= 1'b1;
      fill      <= '0;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      csn_prev  <= csn_sync[SYNC_STAGES-1];
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
      if (fill[SYNC_STAGES] && csn_sync[SYNC_STAGES-1])
        armed <= 1'b1;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign csn_fall = armed & csn_prev & ~csn_s;

  assign wr       = cs & ~rw;
  assign rd_data  = cs & rw & (AD == 2'd0);
  assign rd_clear = rd_data & ~rd_prev;
  assign rx_byte  = {rxsh, mosi_s};

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    shift_in    = 1'b0;
    shift_out   = 1'b0;
    byte_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (csn_fall) begin
          state_next  = ST_SHIFT;
          frame_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (csn_s) begin
          state_next = ST_IDLE;
        end else begin
          shift_in  = sck_rise;
          byte_done = sck_rise && (bitcnt == 3'd7);
          shift_out = sck_fall && (bitcnt != 3'd0);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    load_tx = frame_start | byte_done;
  end

  // Later assignments win: a DATA write re-arms TXF after a load, an OVR set beats its clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxsh     <= '0;
      txsh     <= '0;
      bitcnt   <= '0;
      tx_hold  <= '0;
      rx_hold  <= '0;
      idle_reg <= IDLE_BYTE;
      ctrl     <= '0;
      txf      <= 1'b0;
      rxf      <= 1'b0;
      ovr      <= 1'b0;
      rd_prev  <= 1'b0;
      intr     <= 1'b0;
    end else begin
      rd_prev <= rd_data;
      intr    <= (ctrl[0] & rxf) | (ctrl[1] & ~txf) | (ctrl[2] & ovr);

      if (load_tx) begin
        txsh <= txf ? tx_hold : idle_reg;
        txf  <= 1'b0;
      end else if (shift_out) begin
        txsh <= {txsh[6:0], 1'b0};
      end

      if (frame_start) begin
        bitcnt <= '0;
      end else if (shift_in) begin
        rxsh   <= rx_byte[6:0];
        bitcnt <= bitcnt + 3'd1;
      end

      if (byte_done && (!rxf || rd_clear)) begin
        rx_hold <= rx_byte;
        rxf     <= 1'b1;
      end else if (rd_clear) begin
        rxf <= 1'b0;
      end

      if (wr && AD == 2'd1 && DI[2])
        ovr <= 1'b0;
      if (byte_done && rxf && !rd_clear)
        ovr <= 1'b1;

      if (wr) begin
        case (AD)
          2'd0: begin
            tx_hold <= DI;
            txf     <= 1'b1;
          end
          2'd2:    ctrl     <= DI[2:0];
          2'd3:    idle_reg <= DI;
          default: ;
        endcase
      end
    end
  end

  assign spi_miso = (state == ST_SHIFT) ? txsh[7] : 1'b1;

  always_comb begin
    DO = '0;
    case (AD)
      2'd0: DO = rx_hold;
      2'd1: DO = {3'b000, (state == ST_SHIFT), ~csn_s, ovr, ~txf, rxf};
      2'd2: DO = {5'b00000, ctrl};
      2'd3: DO = idle_reg;
      default: DO = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: directed scenarios plus randomized CPU/host traffic checked
// against a register-level model of the peripheral.
module tb_spi_slave_port;
  localparam int SYNC = 2;
  localparam int HP   = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] AD = 2'd0;
  logic [7:0] DI = 8'h00;
  wire  [7:0] DO;
  logic       rw = 1'b1, cs = 1'b0;
  logic       spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  wire        spi_miso, intr;

  int errors = 0;
  int checks = 0;

  // Model of the peripheral: hold registers, flags and the byte the shifter is sending
  bit         m_txf, m_rxf, m_ovr, frame_ok, settled;
  logic [7:0] m_tx, m_rx, m_idle, cur_tx;
  logic [2:0] m_ctrl;

  always #5 CLK = ~CLK;

  spi_slave_port #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .CLK(CLK), .RESET(RESET), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .intr(intr)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_intr();
    return (m_ctrl[0] & m_rxf) | (m_ctrl[1] & ~m_txf) | (m_ctrl[2] & m_ovr);
  endfunction

  function automatic logic [7:0] m_status(input bit active);
    return {3'b000, active, ~spi_cs_n, m_ovr, ~m_txf, m_rxf};
  endfunction

  // Whenever the bench is quiet, intr and an idle MISO must match the model every cycle
  always @(negedge CLK) begin
    if (settled) begin
      checkOutput("intr_vs_model", {7'b0, intr}, {7'b0, m_intr()});
      if (spi_cs_n)
        checkOutput("miso_idle", {7'b0, spi_miso}, 8'h01);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_txf = 0; m_rxf = 0; m_ovr = 0; frame_ok = 0;
    m_tx = 8'h00; m_rx = 8'h00; m_idle = 8'hFF; m_ctrl = 3'b000; cur_tx = 8'hFF;
  endtask

  task automatic settleWait();
    repeat (SYNC + 4) @(posedge CLK);
    @(negedge CLK);
    settled = 1;
  endtask

  task automatic applyReset();
    settled = 0;
    @(negedge CLK) RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    modelReset();
    settleWait();
  endtask

  task automatic cpuWrite(input logic [1:0] ad, input logic [7:0] d);
    settled = 0;
    @(negedge CLK);
    cs = 1'b1; rw = 1'b0; AD = ad; DI = d;
    @(negedge CLK);
    cs = 1'b0; rw = 1'b1;
    case (ad)
      2'd0: begin m_tx = d; m_txf = 1; end
      2'd1: if (d[2]) m_ovr = 0;
      2'd2: m_ctrl = d[2:0];
      2'd3: m_idle = d;
      default: ;
    endcase
  endtask

  task automatic cpuRead(input logic [1:0] ad, output logic [7:0] d);
    settled = 0;
    @(negedge CLK);
    cs = 1'b1; rw = 1'b1; AD = ad;
    #2 d = DO;
    @(negedge CLK);
    cs = 1'b0;
    @(negedge CLK);
    if (ad == 2'd0) m_rxf = 0;
  endtask

  task automatic hostStart();
    settled = 0;
    spi_cs_n = 1'b0;
    repeat (HP) @(negedge CLK);
    frame_ok = 1;
    cur_tx = m_txf ? m_tx : m_idle;
    m_txf = 0;
  endtask

  task automatic hostEnd();
    repeat (HP) @(negedge CLK);
    spi_cs_n = 1'b1;
    frame_ok = 0;
    settleWait();
  endtask

  // Clocks n bits out of data, checking each MISO bit against the byte the model says is loaded
  task automatic applyStimulus(input int n, input logic [7:0] data, input bit watch,
                               output logic [7:0] got);
    int lat;
    settled = 0;
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = data[7-i];
      repeat (HP) @(negedge CLK);
      got[7-i] = spi_miso;
      checkOutput($sformatf("miso_bit%0d", i), {7'b0, spi_miso},
                  {7'b0, (frame_ok ? cur_tx[7-i] : 1'b1)});
      spi_sck = 1'b1;
      if (watch && i == n - 1) begin
        lat = -1;
        for (int c = 1; c <= HP; c++) begin
          @(negedge CLK);
          if (intr === 1'b1 && lat < 0) lat = c;
        end
        checkOutput("intr_latency", {7'b0, (lat >= 1 && lat <= SYNC + 3)}, 8'h01);
      end else begin
        repeat (HP) @(negedge CLK);
      end
      spi_sck = 1'b0;
    end
    if (n == 8 && frame_ok) begin
      if (!m_rxf) begin m_rx = data; m_rxf = 1; end
      else m_ovr = 1;
      cur_tx = m_txf ? m_tx : m_idle;
      m_txf = 0;
    end
  endtask

  initial begin
    logic [7:0] d, g1, g2, exp;
    settled = 0;
    modelReset();
    applyReset();

    // Reset state
    cpuRead(2'd1, d); checkOutput("rst_status", d, 8'h02);
    cpuRead(2'd0, d); checkOutput("rst_data", d, 8'h00);
    cpuRead(2'd2, d); checkOutput("rst_ctrl", d, 8'h00);
    cpuRead(2'd3, d); checkOutput("rst_idle", d, 8'hFF);
    checkOutput("rst_intr", {7'b0, intr}, 8'h00);
    checkOutput("rst_miso", {7'b0, spi_miso}, 8'h01);

    // Queued TX byte goes out while a byte comes in
    cpuWrite(2'd0, 8'hA5); settleWait();
    hostStart(); applyStimulus(8, 8'h3C, 0, g1); hostEnd();
    checkOutput("a5_miso", g1, 8'hA5);
    cpuRead(2'd1, d); checkOutput("a5_status_rxf", d, 8'h03);
    cpuRead(2'd0, d); checkOutput("a5_data", d, 8'h3C);
    cpuRead(2'd1, d); checkOutput("a5_status_clr", d, 8'h02);

    // Idle byte twice, second byte overruns
    cpuWrite(2'd3, 8'h5A); settleWait();
    hostStart(); applyStimulus(8, 8'h11, 0, g1); applyStimulus(8, 8'h22, 0, g2); hostEnd();
    checkOutput("idle_miso1", g1, 8'h5A);
    checkOutput("idle_miso2", g2, 8'h5A);
    cpuRead(2'd1, d); checkOutput("ovr_status", d, 8'h07);
    cpuRead(2'd0, d); checkOutput("ovr_data", d, 8'h11);
    cpuWrite(2'd1, 8'h04); settleWait();
    cpuRead(2'd1, d); checkOutput("ovr_cleared", d, 8'h02);

    // RX interrupt latency and clear-on-read
    cpuWrite(2'd2, 8'h01); settleWait();
    hostStart(); applyStimulus(8, 8'h81, 1, g1); hostEnd();
    settled = 0;
    @(negedge CLK); cs = 1'b1; rw = 1'b1; AD = 2'd0;
    #2 d = DO;
    @(posedge CLK);
    @(negedge CLK); cs = 1'b0; m_rxf = 0;
    @(posedge CLK); #1;
    checkOutput("intr_rd_data", d, 8'h81);
    checkOutput("intr_low_after_read", {7'b0, intr}, 8'h00);
    cpuWrite(2'd2, 8'h00); settleWait();

    // Aborted frame after 4 bits, then a full frame
    hostStart(); applyStimulus(4, 8'hF0, 0, g1);
    repeat (HP) @(negedge CLK);
    cpuRead(2'd1, d); checkOutput("partial_active", d, 8'h1A);
    hostEnd();
    cpuRead(2'd1, d); checkOutput("partial_status", d, 8'h02);
    hostStart(); applyStimulus(8, 8'hC3, 0, g1); hostEnd();
    cpuRead(2'd0, d); checkOutput("after_partial_data", d, 8'hC3);

    // Reset in the middle of a frame with cs_n held low
    hostStart(); applyStimulus(3, 8'hE0, 0, g1);
    applyReset();
    checkOutput("midrst_miso", {7'b0, spi_miso}, 8'h01);
    applyStimulus(5, 8'h1F, 0, g1);
    repeat (HP) @(negedge CLK);
    cpuRead(2'd1, d); checkOutput("midrst_status", d, 8'h0A);
    hostEnd();
    hostStart(); applyStimulus(8, 8'h96, 0, g1); hostEnd();
    checkOutput("midrst_next_miso", g1, 8'hFF);
    cpuRead(2'd0, d); checkOutput("midrst_next_data", d, 8'h96);

    // DATA write in the very cycle the frame-start load happens
    cpuWrite(2'd3, 8'h3E); settleWait();
    settled = 0;
    @(posedge CLK); #1 spi_cs_n = 1'b0;
    repeat (SYNC) @(posedge CLK);
    @(negedge CLK); cs = 1'b1; rw = 1'b0; AD = 2'd0; DI = 8'hB7;
    @(negedge CLK); cs = 1'b0; rw = 1'b1;
    frame_ok = 1; cur_tx = m_idle; m_tx = 8'hB7; m_txf = 1;
    repeat (HP) @(negedge CLK);
    applyStimulus(8, 8'h44, 0, g1); applyStimulus(8, 8'h55, 0, g2); hostEnd();
    checkOutput("coinc_first", g1, 8'h3E);
    checkOutput("coinc_second", g2, 8'hB7);
    cpuRead(2'd0, d); checkOutput("coinc_data", d, 8'h44);
    cpuWrite(2'd1, 8'h04); settleWait();

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 7))
        0: cpuWrite(2'd0, 8'($urandom));
        1: cpuWrite(2'd2, 8'($urandom));
        2: cpuWrite(2'd3, 8'($urandom));
        3: begin exp = m_rx; cpuRead(2'd0, d); checkOutput("rnd_data", d, exp); end
        4: begin exp = m_status(0); cpuRead(2'd1, d); checkOutput("rnd_status", d, exp); end
        5: cpuWrite(2'd1, 8'h04);
        6: begin
          hostStart();
          for (int b = 0, nb = $urandom_range(1, 3); b < nb; b++)
            applyStimulus(8, 8'($urandom), 0, g1);
          hostEnd();
        end
        default: begin
          hostStart(); applyStimulus($urandom_range(1, 7), 8'($urandom), 0, g1); hostEnd();
        end
      endcase
      settleWait();
    end
    exp = m_status(0); cpuRead(2'd1, d); checkOutput("final_status", d, exp);

    settled = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
